duty_cycle_meter: RTL and testbench
===================================

DUTY_CYCLE_METER -- requirements
Module: duty_cycle_meter

Interface
REQ-001 The block SHALL take parameter CNT_W, default 8, as the width of the high-time and period counters and outputs (legal range 4..16).
REQ-002 The block SHALL take parameter SYNC_STAGES, default 2, as the depth of the input synchronizer (legal range 2..3).
REQ-003 clockin  input  1  The single clock, rising edge; all state is clocked only by clockin.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 enable  input  1  Measurement enable, synchronous to clockin.
REQ-006 sig_in  input  1  Divided clock or waveform under measurement; may be asynchronous to clockin.
REQ-007 high_count  output  CNT_W  High time of the last completed period, in clockin cycles.
REQ-008 period_count  output  CNT_W  Length of the last completed period, in clockin cycles.
REQ-009 meas_valid  output  1  One-cycle pulse; high_count and period_count were updated.
REQ-010 overflow  output  1  Sticky flag; a period or high phase exceeded 2^CNT_W-1 cycles.

Function
REQ-011 sig_in SHALL pass through SYNC_STAGES flops to produce sig_s.
- A further flop SHALL hold sig_p, the previous value of sig_s.
- rise = sig_s & ~sig_p.
- fall = ~sig_s & sig_p.
REQ-012 The block SHALL implement an FSM with the states IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW.
REQ-013 Transitions SHALL be:
- IDLE -> WAIT_RISE when enable=1.
- WAIT_RISE -> MEAS_HIGH on rise.
- MEAS_HIGH -> MEAS_LOW on fall.
- MEAS_LOW -> MEAS_HIGH on rise, which completes a measurement.
REQ-014 On every rise accepted in WAIT_RISE or MEAS_LOW, the internal counters SHALL load hi_cnt=1 and per_cnt=1.
- The cycle in which rise is detected counts as cycle 1.
REQ-015 In MEAS_HIGH, each cycle without fall SHALL increment both hi_cnt and per_cnt.
REQ-016 On fall, and in each MEAS_LOW cycle without rise, only per_cnt SHALL increment.
REQ-017 On a rise in MEAS_LOW, the block SHALL:
- register high_count<=hi_cnt and period_count<=per_cnt at that clockin edge;
- drive meas_valid=1 for exactly the following cycle;
- restart counting per REQ-014 in the same edge, so back-to-back periods are each reported.
REQ-018 Latency from a sig_in rising edge (meeting setup) to meas_valid SHALL be SYNC_STAGES+1 clockin edges.
REQ-019 high_count and period_count SHALL hold their last values until the next completed measurement.
- enable=0 SHALL NOT clear them.
REQ-020 If an increment of hi_cnt or per_cnt would pass 2^CNT_W-1, the block SHALL:
- set overflow=1;
- go to WAIT_RISE;
- discard the partial measurement, with no meas_valid for that period.
REQ-021 overflow SHALL stay 1 until reset or a cycle with enable=0.
REQ-022 enable=0 in any state SHALL force IDLE on the next edge.
- Counters clear, meas_valid=0, overflow clears.
- The synchronizer keeps running.
REQ-023 Re-asserting enable SHALL always start in WAIT_RISE.
- The first period after enable is never reported, because an in-progress high phase is never treated as a rise.
REQ-024 Minimum measurable waveform SHALL be 1 cycle high and 1 cycle low, giving high_count=1 and period_count=2.
REQ-025 meas_valid SHALL never be asserted while overflow is being set in the same cycle.

Reset
REQ-026 While reset=1, the block SHALL asynchronously force:
- state=IDLE;
- all synchronizer flops, sig_p, hi_cnt and per_cnt to 0;
- high_count=0, period_count=0, meas_valid=0, overflow=0.
REQ-027 After reset deasserts, the block SHALL resume per REQ-013 on the first clockin edge.
- An in-progress measurement is never completed across reset.

Verification
REQ-028 The bench SHALL cover these directed scenarios with the default parameters unless stated:
- 10 ns clockin, reset=1 for 20 ns, enable=1, sig_in = divide-by-4 at 50% duty (2 high, 2 low) -> first meas_valid reports high_count=2, period_count=4, then one pulse every 4 cycles with identical values.
- sig_in = divide-by-4 at 25% duty (1 high, 3 low) -> high_count=1, period_count=4; sig_in = divide-by-2 -> high_count=1, period_count=2, with meas_valid every 2 cycles.
- CNT_W=4, sig_in held 1 for 20 cycles after a rise -> overflow=1 when hi_cnt would reach 16, no meas_valid, outputs unchanged; a later 3 high/3 low waveform reports 3/6 while overflow stays 1.
- enable dropped for 1 cycle mid-MEAS_LOW -> overflow clears, no meas_valid for that period, next report arrives after one full unreported period, outputs hold prior values meanwhile.
- reset pulsed mid-MEAS_HIGH asynchronously (between clockin edges) -> all outputs are 0 immediately; after release with a 50% divide-by-4 waveform, the first report is 2/4.
- Check meas_valid is exactly one cycle wide and latency is SYNC_STAGES+1 edges from sig_in rise.

Source files
------------

// File: rtl/duty_cycle_meter.sv
// Measures high time and period of a (possibly asynchronous) waveform in clockin cycles.
// Reports one high/period pair per completed rise-to-rise period; sticky overflow on counter saturation.
module duty_cycle_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clockin,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             meas_valid,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sig_p_r;
    logic                   sig_s;
    logic                   rise_s;
    logic                   fall_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       hi_cnt_r;
    logic [CNT_W-1:0]       per_cnt_r;
    logic [CNT_W-1:0]       hi_nxt_s;
    logic [CNT_W-1:0]       per_nxt_s;
    logic                   report_s;
    logic                   ovf_set_s;
    logic                   hi_full_s;
    logic                   per_full_s;

    // Input synchronizer plus one-cycle history for edge detection
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            sync_r  <= '0;
            sig_p_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], sig_in};
            sig_p_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sig_s      = sync_r[SYNC_STAGES-1];
    assign rise_s     = sig_s & ~sig_p_r;
    assign fall_s     = ~sig_s & sig_p_r;
    assign hi_full_s  = &hi_cnt_r;
    assign per_full_s = &per_cnt_r;

    // Next-state and counter update; saturation aborts the period without a report
    always_comb begin
        state_nxt_s = state_r;
        hi_nxt_s    = hi_cnt_r;
        per_nxt_s   = per_cnt_r;
        report_s    = 1'b0;
        ovf_set_s   = 1'b0;
        if (!enable) begin
            state_nxt_s = IDLE;
            hi_nxt_s    = '0;
            per_nxt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise_s) begin
                        state_nxt_s = MEAS_HIGH;
                        hi_nxt_s    = CNT_ONE;
                        per_nxt_s   = CNT_ONE;
                    end else begin
                        state_nxt_s = WAIT_RISE;
                    end
                end
                MEAS_HIGH: begin
                    if (fall_s) begin
                        if (per_full_s) begin
                            ovf_set_s   = 1'b1;
                            state_nxt_s = WAIT_RISE;
                            hi_nxt_s    = '0;
                            per_nxt_s   = '0;
                        end else begin
                            state_nxt_s = MEAS_LOW;
                            per_nxt_s   = per_cnt_r + CNT_ONE;
                        end
                    end else if (hi_full_s || per_full_s) begin
                        ovf_set_s   = 1'b1;
                        state_nxt_s = WAIT_RISE;
                        hi_nxt_s    = '0;
                        per_nxt_s   = '0;
                    end else begin
                        hi_nxt_s  = hi_cnt_r + CNT_ONE;
                        per_nxt_s = per_cnt_r + CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (rise_s) begin
                        report_s    = 1'b1;
                        state_nxt_s = MEAS_HIGH;
                        hi_nxt_s    = CNT_ONE;
                        per_nxt_s   = CNT_ONE;
                    end else if (per_full_s) begin
                        ovf_set_s   = 1'b1;
                        state_nxt_s = WAIT_RISE;
                        hi_nxt_s    = '0;
                        per_nxt_s   = '0;
                    end else begin
                        per_nxt_s = per_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    hi_nxt_s    = '0;
                    per_nxt_s   = '0;
                end
            endcase
        end
    end

    // State and working counters
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            hi_cnt_r  <= '0;
            per_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            hi_cnt_r  <= hi_nxt_s;
            per_cnt_r <= per_nxt_s;
        end
    end

    // Registered results: captured on a completed period, held otherwise
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            high_count   <= '0;
            period_count <= '0;
            meas_valid   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            meas_valid <= report_s;
            if (report_s) begin
                high_count   <= hi_cnt_r;
                period_count <= per_cnt_r;
            end
            if (!enable) begin
                overflow <= 1'b0;
            end else if (ovf_set_s) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Self-checking bench: two instances (8-bit/2-stage and 4-bit/3-stage) share stimulus and
// are compared every cycle against a timestamp-based reference model, plus directed checks.
module tb_duty_cycle_meter;

    logic       clockin;
    logic       reset;
    logic       enable;
    logic       sig_in;
    logic [7:0] hc0, pc0;
    logic       mv0, ov0;
    logic [3:0] hc1, pc1;
    logic       mv1, ov1;

    duty_cycle_meter #(.CNT_W(8), .SYNC_STAGES(2)) u_dut0 (
        .clockin(clockin), .reset(reset), .enable(enable), .sig_in(sig_in),
        .high_count(hc0), .period_count(pc0), .meas_valid(mv0), .overflow(ov0)
    );

    duty_cycle_meter #(.CNT_W(4), .SYNC_STAGES(3)) u_dut1 (
        .clockin(clockin), .reset(reset), .enable(enable), .sig_in(sig_in),
        .high_count(hc1), .period_count(pc1), .meas_valid(mv1), .overflow(ov1)
    );

    initial clockin = 1'b0;
    always #5 clockin = ~clockin;

    int vectors = 0;
    int errors  = 0;

    // reference model: per instance, timestamps of the accepted rise and last fall
    int         edge_n;
    int         stages [2];
    int         maxv   [2];
    logic [3:0] qv     [2];
    bit         ready  [2];
    bit         meas   [2];
    int         r_t    [2];
    int         f_t    [2];
    int         m_hi   [2];
    int         m_per  [2];
    bit         m_valid[2];
    bit         m_ovf  [2];
    int         pulses0, pulses1;

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_hi;
        int exp_per;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            qv[i] = 4'd0; ready[i] = 1'b0; meas[i] = 1'b0;
            r_t[i] = 0; f_t[i] = 0; m_hi[i] = 0; m_per[i] = 0;
            m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i, input bit en, input bit s);
        bit ss, sp, rise, fall;
        ss   = qv[i][stages[i]-1];
        sp   = qv[i][stages[i]];
        rise = ss & ~sp;
        fall = ~ss & sp;
        m_valid[i] = 1'b0;
        if (!en) begin
            ready[i] = 1'b0; meas[i] = 1'b0; m_ovf[i] = 1'b0;
        end else if (!ready[i]) begin
            ready[i] = 1'b1;
        end else if (rise) begin
            if (meas[i]) begin
                m_hi[i]    = f_t[i] - r_t[i];
                m_per[i]   = edge_n - r_t[i];
                m_valid[i] = 1'b1;
            end
            meas[i] = 1'b1;
            r_t[i]  = edge_n;
        end else if (meas[i]) begin
            if (fall) f_t[i] = edge_n;
            if (edge_n - r_t[i] + 1 > maxv[i]) begin
                m_ovf[i] = 1'b1;
                meas[i]  = 1'b0;
            end
        end
        qv[i] = {qv[i][2:0], s};
    endtask

    task automatic step(input bit en, input bit s);
        enable = en;
        sig_in = s;
        @(posedge clockin);
        edge_n++;
        model_edge(0, en, s);
        model_edge(1, en, s);
        @(negedge clockin);
        check("hc0", {24'd0, hc0}, m_hi[0]);
        check("pc0", {24'd0, pc0}, m_per[0]);
        check("mv0", {31'd0, mv0}, {31'd0, m_valid[0]});
        check("ov0", {31'd0, ov0}, {31'd0, m_ovf[0]});
        check("hc1", {28'd0, hc1}, m_hi[1]);
        check("pc1", {28'd0, pc1}, m_per[1]);
        check("mv1", {31'd0, mv1}, {31'd0, m_valid[1]});
        check("ov1", {31'd0, ov1}, {31'd0, m_ovf[1]});
        if (mv0 === 1'b1) pulses0++;
        if (mv1 === 1'b1) pulses1++;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < hi; k++) step(1'b1, 1'b1);
            for (int k = 0; k < lo; k++) step(1'b1, 1'b0);
        end
    endtask

    task automatic lows(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0);
    endtask

    task automatic settle();
        step(1'b0, 1'b0);
        lows(4);
        pulses0 = 0;
        pulses1 = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hc0"}, {24'd0, hc0}, 32'd0);
        check({tag, "_pc0"}, {24'd0, pc0}, 32'd0);
        check({tag, "_mv0"}, {31'd0, mv0}, 32'd0);
        check({tag, "_ov0"}, {31'd0, ov0}, 32'd0);
        check({tag, "_hc1"}, {28'd0, hc1}, 32'd0);
        check({tag, "_pc1"}, {28'd0, pc1}, 32'd0);
        check({tag, "_mv1"}, {31'd0, mv1}, 32'd0);
        check({tag, "_ov1"}, {31'd0, ov1}, 32'd0);
    endtask

    initial begin
        int rise2, lat0, lat1, dbl0, dbl1;
        int hold_hi, hold_per;
        bit prev0, prev1, en;

        stages[0] = 2; stages[1] = 3;
        maxv[0]   = 255; maxv[1] = 15;
        edge_n = 0;
        pulses0 = 0; pulses1 = 0;
        model_clear();
        reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
        #12;
        check_zero("reset");
        #8;
        reset = 1'b0;

        // table-driven waveforms
        tbl[0] = '{2, 2, 6, 2, 4};
        tbl[1] = '{1, 3, 5, 1, 4};
        tbl[2] = '{1, 1, 8, 1, 2};
        tbl[3] = '{3, 3, 4, 3, 6};
        tbl[4] = '{5, 2, 4, 5, 7};
        for (int t = 0; t < 5; t++) begin
            settle();
            wave(tbl[t].hi, tbl[t].lo, tbl[t].n);
            lows(4);
            check("tbl_hc0", {24'd0, hc0}, tbl[t].exp_hi);
            check("tbl_pc0", {24'd0, pc0}, tbl[t].exp_per);
            check("tbl_hc1", {28'd0, hc1}, tbl[t].exp_hi);
            check("tbl_pc1", {28'd0, pc1}, tbl[t].exp_per);
            check("tbl_pulses0", pulses0, tbl[t].n - 1);
            check("tbl_pulses1", pulses1, tbl[t].n - 1);
        end

        // latency and pulse width with a 2-high/2-low waveform
        settle();
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        rise2 = edge_n;
        lat0 = -1; lat1 = -1; dbl0 = 0; dbl1 = 0; prev0 = 1'b0; prev1 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, (k % 4) < 2);
            if (mv0 === 1'b1 && lat0 < 0) lat0 = edge_n - rise2;
            if (mv1 === 1'b1 && lat1 < 0) lat1 = edge_n - rise2;
            if (mv0 === 1'b1 && prev0) dbl0++;
            if (mv1 === 1'b1 && prev1) dbl1++;
            prev0 = mv0;
            prev1 = mv1;
        end
        check("latency0", lat0, 2);
        check("latency1", lat1, 3);
        check("width0", dbl0, 0);
        check("width1", dbl1, 0);

        // long high phase saturates the 4-bit instance only
        settle();
        hold_hi = hc1; hold_per = pc1;
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1);
        check("ovf_set1", {31'd0, ov1}, 32'd1);
        check("ovf_hold_hc1", {28'd0, hc1}, hold_hi);
        check("ovf_hold_pc1", {28'd0, pc1}, hold_per);
        check("ovf_pulses1", pulses1, 0);
        lows(3);
        wave(3, 3, 4);
        lows(4);
        check("ovf_after_hc1", {28'd0, hc1}, 32'd3);
        check("ovf_after_pc1", {28'd0, pc1}, 32'd6);
        check("ovf_sticky1", {31'd0, ov1}, 32'd1);

        // enable dropped for one cycle during the low phase
        wave(2, 2, 3);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("endrop_ov1", {31'd0, ov1}, 32'd0);
        check("endrop_hc0", {24'd0, hc0}, 32'd2);
        check("endrop_pc0", {24'd0, pc0}, 32'd4);
        pulses0 = 0;
        step(1'b1, 1'b0);
        wave(2, 2, 3);
        lows(4);
        check("endrop_pulses0", pulses0, 2);

        // asynchronous reset in the middle of a high phase
        settle();
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        check("pre_reset_hc0", {24'd0, hc0}, 32'd2);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        model_clear();
        @(posedge clockin);
        @(negedge clockin);
        reset = 1'b0;
        pulses0 = 0;
        wave(2, 2, 3);
        lows(4);
        check("post_reset_hc0", {24'd0, hc0}, 32'd2);
        check("post_reset_pc0", {24'd0, pc0}, 32'd4);
        check("post_reset_pulses0", pulses0, 2);

        // randomized waveforms with occasional enable drops
        for (int p = 0; p < 200; p++) begin
            int hi, lo;
            hi = $urandom_range(1, 20);
            lo = $urandom_range(1, 20);
            for (int k = 0; k < hi + lo; k++) begin
                en = ($urandom_range(0, 39) != 0);
                step(en, k < hi);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
